// File: rtl/riscv_bif_arb_if.sv
// riscv_bif_arb_if: signal bundle for the riscv_bif_arb arbiter.
//
// Carries both requester ports (ibif_*, dbif_*) and the shared memory
// port (mem_*). Every port uses a rdy/ack handshake: rdy and its fields
// are held until a one-cycle ack, and rdata is valid only with ack.
//
// Modports:
//   master - the arbiter's view. It receives requests from fetch/data,
//            returns their acks and data, and drives the memory bus as
//            its master.
//   slave  - the environment's view: the fetch unit, the data-side unit
//            and the memory that answers the bus.
interface riscv_bif_arb_if;
  // instruction fetch requester
  logic        ibif_rdy;
  logic [31:0] ibif_addr;
  logic        ibif_ack;
  logic [31:0] ibif_rdata;

  // data-side requester
  logic        dbif_rdy;
  logic [31:0] dbif_addr;
  logic        dbif_rnw;
  logic [31:0] dbif_wdata;
  logic [3:0]  dbif_wmask;
  logic        dbif_ack;
  logic [31:0] dbif_rdata;

  // shared memory bus
  logic        mem_rdy;
  logic [31:0] mem_addr;
  logic        mem_rnw;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  ibif_rdy, ibif_addr,
    output ibif_ack, ibif_rdata,
    input  dbif_rdy, dbif_addr, dbif_rnw, dbif_wdata, dbif_wmask,
    output dbif_ack, dbif_rdata,
    output mem_rdy, mem_addr, mem_rnw, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output ibif_rdy, ibif_addr,
    input  ibif_ack, ibif_rdata,
    output dbif_rdy, dbif_addr, dbif_rnw, dbif_wdata, dbif_wmask,
    input  dbif_ack, dbif_rdata,
    input  mem_rdy, mem_addr, mem_rnw, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/riscv_bif_arb.sv
// riscv_bif_arb: two-master arbiter sharing one memory bus between
// instruction fetch (ibif) and the memory stage (dbif).
//
// One master owns the bus per transaction. Data wins by fixed priority,
// except that after STARVE_MAX consecutive data grants made while fetch
// was waiting, fetch is forced to win the next arbitration. After every
// mem_ack the bus returns to IDLE for one turnaround cycle.
//
// Parameters:
//   STARVE_MAX - data grants tolerated while fetch waits (1..15)
//   CNT_W      - starvation counter width, must hold STARVE_MAX
//
// Ports:
//   clk     - clock
//   rst     - synchronous reset, active-high
//   bif     - requester and memory bus bundle (arbiter side)
//   grant_d - registered: current or last owner was the data side
module riscv_bif_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_bif_arb_if.master       bif,
  output logic                  grant_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             fetch_forced;

  // Fetch is forced only when it is actually waiting and data has
  // already won STARVE_MAX times in a row against it.
  assign fetch_forced = bif.ibif_rdy && (starve_q >= STARVE_LIM);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (bif.dbif_rdy && !fetch_forced) begin
          state_d = GNT_D;
          if (bif.ibif_rdy && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (bif.ibif_rdy) begin
          state_d  = GNT_I;
          starve_d = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (bif.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      grant_d  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      // Grants are only ever entered from IDLE.
      if (state_q == IDLE && state_d == GNT_D) begin
        grant_d <= 1'b1;
      end else if (state_q == IDLE && state_d == GNT_I) begin
        grant_d <= 1'b0;
      end
    end
  end

  // Bus fields follow the owning master combinationally so that a
  // request reaches mem_rdy in the cycle after arbitration.
  always_comb begin
    bif.mem_rdy   = 1'b0;
    bif.mem_addr  = '0;
    bif.mem_rnw   = 1'b1;
    bif.mem_wdata = '0;
    bif.mem_wmask = '0;
    bif.ibif_ack  = 1'b0;
    bif.dbif_ack  = 1'b0;
    unique case (state_q)
      GNT_I: begin
        bif.mem_rdy  = bif.ibif_rdy;
        bif.mem_addr = bif.ibif_addr;
        // A reset in the same cycle abandons the transaction, so the
        // master must not see it complete.
        bif.ibif_ack = bif.mem_ack && !rst;
      end
      GNT_D: begin
        bif.mem_rdy   = bif.dbif_rdy;
        bif.mem_addr  = bif.dbif_addr;
        bif.mem_rnw   = bif.dbif_rnw;
        bif.mem_wdata = bif.dbif_wdata;
        bif.mem_wmask = bif.dbif_wmask;
        bif.dbif_ack  = bif.mem_ack && !rst;
      end
      default: begin
      end
    endcase
  end

  assign bif.ibif_rdata = bif.mem_rdata;
  assign bif.dbif_rdata = bif.mem_rdata;

endmodule

// File: tb/tb_riscv_bif_arb.sv
// tb_riscv_bif_arb: self-checking bench for riscv_bif_arb.
// Directed vector table, hand-written multi-cycle sequences (starvation
// ordering, reset during a transaction) and a randomized run against a
// transaction-level reference model.
module tb_riscv_bif_arb;

  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic grant_d;

  riscv_bif_arb_if bif ();

  riscv_bif_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bif     (bif),
    .grant_d (grant_d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic        rnw;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        ack;
    logic [31:0] rd;
    logic        e_rdy;
    logic [31:0] e_addr;
    logic        e_rnw;
    logic [31:0] e_wd;
    logic [3:0]  e_wm;
    logic        e_iack;
    logic        e_dack;
    logic        e_gd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da, input logic rnw,
                        input logic [31:0] wd, input logic [3:0] wm,
                        input logic ack, input logic [31:0] rd);
    rst            = r;
    bif.ibif_rdy   = ir;
    bif.ibif_addr  = ia;
    bif.dbif_rdy   = dr;
    bif.dbif_addr  = da;
    bif.dbif_rnw   = rnw;
    bif.dbif_wdata = wd;
    bif.dbif_wmask = wm;
    bif.mem_ack    = ack;
    bif.mem_rdata  = rd;
  endtask

  task automatic chk_out(input string tag, input logic e_rdy, input logic [31:0] e_addr,
                         input logic e_rnw, input logic [31:0] e_wd, input logic [3:0] e_wm,
                         input logic e_iack, input logic e_dack, input logic e_gd,
                         input logic [31:0] e_rd);
    chk({tag, ".mem_rdy"},   32'(bif.mem_rdy),   32'(e_rdy));
    chk({tag, ".mem_addr"},  bif.mem_addr,       e_addr);
    chk({tag, ".mem_rnw"},   32'(bif.mem_rnw),   32'(e_rnw));
    chk({tag, ".mem_wdata"}, bif.mem_wdata,      e_wd);
    chk({tag, ".mem_wmask"}, 32'(bif.mem_wmask), 32'(e_wm));
    chk({tag, ".ibif_ack"},  32'(bif.ibif_ack),  32'(e_iack));
    chk({tag, ".dbif_ack"},  32'(bif.dbif_ack),  32'(e_dack));
    chk({tag, ".grant_d"},   32'(grant_d),       32'(e_gd));
    if (e_iack) chk({tag, ".ibif_rdata"}, bif.ibif_rdata, e_rd);
    if (e_dack) chk({tag, ".dbif_rdata"}, bif.dbif_rdata, e_rd);
  endtask

  function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                              input logic dr, input logic [31:0] da, input logic rnw,
                              input logic [31:0] wd, input logic [3:0] wm,
                              input logic ack, input logic [31:0] rd,
                              input logic e_rdy, input logic [31:0] e_addr, input logic e_rnw,
                              input logic [31:0] e_wd, input logic [3:0] e_wm,
                              input logic e_iack, input logic e_dack, input logic e_gd,
                              input logic [31:0] e_rd);
    vec_t v;
    v.rst = r;   v.ir = ir;   v.ia = ia;   v.dr = dr;   v.da = da;
    v.rnw = rnw; v.wd = wd;   v.wm = wm;   v.ack = ack; v.rd = rd;
    v.e_rdy = e_rdy; v.e_addr = e_addr; v.e_rnw = e_rnw; v.e_wd = e_wd;
    v.e_wm = e_wm; v.e_iack = e_iack; v.e_dack = e_dack; v.e_gd = e_gd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic do_reset(input int unsigned cycles);
    set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, '0, '0, 1'b0, '0);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: who owns the bus, how many data grants fetch has
  // sat through, and who owned it last.
  int m_owner;   // 0 none, 1 fetch, 2 data
  int m_waited;
  bit m_last_d;

  // Random traffic state
  bit          i_pend, d_pend;
  logic [31:0] i_addr, d_addr, d_wd, r_rd;
  logic        d_rnw, r_ack;
  logic [3:0]  d_wm;

  initial begin
    // ---------------- directed table ----------------
    // reset then idle
    tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0,             0,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,             0,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,             0,0,1,0,0,0,0,0,0));
    // single fetch, memory acks two cycles after mem_rdy
    tbl.push_back(mk(0,1,32'h100,0,0,1,0,0,0,0,       0,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h100,0,0,1,0,0,0,0,       1,32'h100,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h100,0,0,1,0,0,0,0,       1,32'h100,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h100,0,0,1,0,0,1,32'h13,  1,32'h100,1,0,0,1,0,0,32'h13));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,             0,0,1,0,0,0,0,0,0));
    // store pass-through
    tbl.push_back(mk(0,0,0,1,32'h2000,0,32'hDEADBEEF,4'b0011,0,0,  0,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h2000,0,32'hDEADBEEF,4'b0011,0,0,
                     1,32'h2000,0,32'hDEADBEEF,4'b0011,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h2000,0,32'hDEADBEEF,4'b0011,1,32'h55,
                     1,32'h2000,0,32'hDEADBEEF,4'b0011,0,1,1,32'h55));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,             0,0,1,0,0,0,0,1,0));
    // stray ack in IDLE, then a normal fetch
    tbl.push_back(mk(0,0,0,0,0,1,0,0,1,32'hAA,        0,0,1,0,0,0,0,1,0));
    tbl.push_back(mk(0,1,32'h104,0,0,1,0,0,0,0,       0,0,1,0,0,0,0,1,0));
    tbl.push_back(mk(0,1,32'h104,0,0,1,0,0,1,32'h77,  1,32'h104,1,0,0,1,0,0,32'h77));
    tbl.push_back(mk(0,0,0,0,0,1,0,0,0,0,             0,0,1,0,0,0,0,0,0));

    set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, '0, '0, 1'b0, '0);
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].da, tbl[i].rnw,
             tbl[i].wd, tbl[i].wm, tbl[i].ack, tbl[i].rd);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_addr, tbl[i].e_rnw,
              tbl[i].e_wd, tbl[i].e_wm, tbl[i].e_iack, tbl[i].e_dack, tbl[i].e_gd, tbl[i].e_rd);
      @(negedge clk);
    end

    // ---------------- starvation ordering ----------------
    begin
      string exp_s;
      string got;
      exp_s = "DDDDIDDDDI";
      got   = "";
      do_reset(2);
      for (int c = 0; c < 20; c++) begin
        set_in(1'b0, 1'b1, 32'h400, 1'b1, 32'h800, 1'b1, '0, '0, 1'b0, 32'(c));
        #1;
        bif.mem_ack = bif.mem_rdy;   // memory answers immediately
        #1;
        if (bif.dbif_ack) got = {got, "D"};
        if (bif.ibif_ack) got = {got, "I"};
        @(negedge clk);
      end
      set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, '0, '0, 1'b0, '0);
      chk("starve.count", 32'(got.len()), 32'(exp_s.len()));
      for (int g = 0; g < exp_s.len(); g++) begin
        if (g < got.len()) chk($sformatf("starve.grant%0d", g), 32'(got[g]), 32'(exp_s[g]));
      end
      @(negedge clk);
    end

    // ---------------- reset during a data transaction ----------------
    do_reset(2);
    set_in(1'b0, 1'b1, 32'h400, 1'b1, 32'h3000, 1'b1, '0, '0, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("rstmid.data_granted", 32'(bif.mem_rdy), 32'd1);
    chk("rstmid.data_addr", bif.mem_addr, 32'h3000);
    rst = 1'b1;
    bif.mem_ack = 1'b1;
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'h400, 1'b0, '0, 1'b1, '0, '0, 1'b0, '0);
    #1;
    chk("rstmid.mem_rdy", 32'(bif.mem_rdy), 32'd0);
    chk("rstmid.dbif_ack", 32'(bif.dbif_ack), 32'd0);
    chk("rstmid.grant_d", 32'(grant_d), 32'd0);
    @(negedge clk);
    bif.mem_ack = 1'b1;
    bif.mem_rdata = 32'h1234;
    #1;
    chk("rstmid.fetch_rdy", 32'(bif.mem_rdy), 32'd1);
    chk("rstmid.fetch_addr", bif.mem_addr, 32'h400);
    chk("rstmid.fetch_ack", 32'(bif.ibif_ack), 32'd1);
    chk("rstmid.fetch_rdata", bif.ibif_rdata, 32'h1234);
    @(negedge clk);

    // ---------------- randomized run against the model ----------------
    do_reset(2);
    m_owner = 0; m_waited = 0; m_last_d = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    i_addr = '0; d_addr = '0; d_wd = '0; d_wm = '0; d_rnw = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic e_rdy, e_rnw, e_iack, e_dack;
      logic [31:0] e_addr, e_wd;
      logic [3:0] e_wm;
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1;
        d_addr = $urandom;
        d_rnw  = 1'($urandom_range(0, 1));
        d_wd   = $urandom;
        d_wm   = 4'($urandom_range(0, 15));
      end
      r_ack = ($urandom_range(0, 2) == 0);
      r_rd  = $urandom;
      set_in(1'b0, i_pend, i_addr, d_pend, d_addr, d_rnw, d_wd, d_wm, r_ack, r_rd);

      e_rdy = 1'b0; e_addr = '0; e_rnw = 1'b1; e_wd = '0; e_wm = '0;
      if (m_owner == 1) begin
        e_rdy = i_pend; e_addr = i_addr;
      end else if (m_owner == 2) begin
        e_rdy = d_pend; e_addr = d_addr; e_rnw = d_rnw; e_wd = d_wd; e_wm = d_wm;
      end
      e_iack = (m_owner == 1) && r_ack;
      e_dack = (m_owner == 2) && r_ack;
      #1;
      chk_out($sformatf("rnd%0d", c), e_rdy, e_addr, e_rnw, e_wd, e_wm,
              e_iack, e_dack, m_last_d, r_rd);

      // advance the model across the coming clock edge
      if (m_owner != 0) begin
        if (r_ack) m_owner = 0;
      end else if (d_pend && !(i_pend && m_waited >= int'(STARVE_MAX))) begin
        m_owner  = 2;
        m_last_d = 1'b1;
        if (i_pend && m_waited < int'(STARVE_MAX)) m_waited++;
      end else if (i_pend) begin
        m_owner  = 1;
        m_last_d = 1'b0;
        m_waited = 0;
      end
      if (e_iack) i_pend = 1'b0;
      if (e_dack) d_pend = 1'b0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_bif_arb.md
Name: riscv_bif_arb

Overview:
- Two-master arbiter that shares the single memory bus interface (bif) between instruction fetch (ibif) and the memory stage (dbif).
- Sits between the fetch unit and the data-side memory unit on one side, and the unified memory port on the other.
- Grants one master per transaction. Data has fixed priority, with a starvation limit that forces an instruction grant.
- Uses the same rdy/ack handshake on every port.

Parameters:
- STARVE_MAX, 4, number of consecutive data grants made while ibif_rdy is pending before instruction fetch is forced to win. Legal range 1..15.
- CNT_W, 4, width of the starvation counter. Must hold STARVE_MAX.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- ibif_rdy  input  1  instruction fetch request; held with ibif_addr until ibif_ack
- ibif_addr  input  32  fetch address
- ibif_ack  output  1  fetch complete; one-cycle pulse
- ibif_rdata  output  32  fetch data; valid when ibif_ack=1
- dbif_rdy  input  1  data request; held with its fields until dbif_ack
- dbif_addr  input  32  data address
- dbif_rnw  input  1  1=read, 0=write
- dbif_wdata  input  32  write data
- dbif_wmask  input  4  byte write mask
- dbif_ack  output  1  data complete; one-cycle pulse
- dbif_rdata  output  32  read data; valid when dbif_ack=1
- mem_rdy  output  1  bus request
- mem_addr  output  32  bus address
- mem_rnw  output  1  bus read/not-write
- mem_wdata  output  32  bus write data
- mem_wmask  output  4  bus byte mask
- mem_ack  input  1  bus completion; one-cycle pulse
- mem_rdata  input  32  bus read data; valid with mem_ack
- grant_d  output  1  debug: the current or last owner was dbif

Behaviour:
- State register: IDLE, GNT_I, GNT_D. All state changes happen on the posedge of clk.
- Reset (rst=1 at posedge):
  - State goes to IDLE and the starvation counter goes to 0.
  - grant_d=0, mem_rdy=0, ibif_ack=0, dbif_ack=0.
  - mem_rnw=1; mem_addr, mem_wdata and mem_wmask are all 0.
  - Reset wins over every other event, including a mem_ack in the same cycle. An in-flight bus transaction is abandoned; the memory side is reset together with this block.
- Transitions out of IDLE:
  - dbif_rdy only -> GNT_D.
  - ibif_rdy only -> GNT_I.
  - Both requesting -> GNT_D if counter < STARVE_MAX, else GNT_I.
  - Neither requesting -> stay in IDLE.
- Transitions out of GNT_x:
  - mem_ack=1 -> IDLE.
  - Otherwise hold. There is no preemption or timeout while granted.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when GNT_D is entered while ibif_rdy=1.
  - Clears to 0 when GNT_I is entered.
  - Otherwise unchanged.
- Bus outputs:
  - In GNT_I: mem_rdy = ibif_rdy, mem_addr = ibif_addr, mem_rnw=1, mem_wdata=0, mem_wmask=0.
  - In GNT_D: mem_rdy = dbif_rdy, and mem_addr, mem_rnw, mem_wdata, mem_wmask = the corresponding dbif_* fields.
  - In IDLE: the reset values above.
- Ack and data return:
  - ibif_ack = mem_ack when in GNT_I, else 0. dbif_ack = mem_ack when in GNT_D, else 0.
  - ibif_rdata and dbif_rdata are both driven from mem_rdata. Each is only meaningful with its own ack.
- Latency:
  - A request in IDLE reaches mem_rdy one cycle later.
  - The earliest master ack is in that same cycle, if memory acks combinationally.
  - After an ack the bus is idle for one cycle (the IDLE turnaround). Minimum spacing between grants is therefore 2 cycles.
- Stray ack: mem_ack while in IDLE is ignored. No master ack is generated and the state is unchanged.
- A master dropping rdy before its ack is a protocol violation. mem_rdy follows it; the bench must not do this except in the negative test.
- grant_d is registered: set on entry to GNT_D, cleared on entry to GNT_I.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then no requests -> mem_rdy=0, both acks 0, mem_rnw=1, grant_d=0 on every cycle.
- Single fetch: ibif_rdy=1, addr=0x0000_0100; memory acks 2 cycles after mem_rdy with rdata=0x0000_0013 -> mem_addr=0x100, mem_rnw=1 from cycle+1; ibif_ack pulses once with ibif_rdata=0x13; the next cycle is IDLE.
- Store pass-through: dbif_rdy, addr=0x2000, rnw=0, wdata=0xDEAD_BEEF, wmask=0011 -> the bus carries identical fields; dbif_ack pulses once; ibif_ack stays 0.
- Simultaneous requests with STARVE_MAX=4: both rdy held continuously, memory acks immediately -> grant order D,D,D,D,I,D,D,D,D,I; the counter returns to 0 after each I grant.
- Stray ack: mem_ack=1 in IDLE -> no ibif_ack or dbif_ack, state stays IDLE, counter unchanged.
- Reset mid-transaction: GNT_D with mem_rdy=1, then rst=1 coinciding with mem_ack -> dbif_ack=0 and mem_rdy=0 next cycle; after release a pending ibif_rdy is granted normally.
